// File: rtl/transfer_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// transfer_sequencer_pkg
//   Shared definitions for the block-transfer sequencer:
//   - DEFAULT_DATA_LENGTH : default address / word-count width
//   - S_* localparams     : 3-bit FSM state encodings
//   - state_e             : FSM state type built on those encodings
// -----------------------------------------------------------------------------
package transfer_sequencer_pkg;

  localparam int DEFAULT_DATA_LENGTH = 8;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_XFER = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE = S_IDLE,
    ST_LOAD = S_LOAD,
    ST_WAIT = S_WAIT,
    ST_XFER = S_XFER,
    ST_DONE = S_DONE
  } state_e;

endpackage

// File: rtl/transfer_sequencer_counter.sv
// -----------------------------------------------------------------------------
// transfer_sequencer_counter
//   Loadable down-counter holding the number of words still to transfer.
//   Decrement wraps modulo 2^W, so a loaded 0 yields 2^W decrements before
//   reaching 1 -> 0 again.
// Ports:
//   clk    in   clock
//   res    in   async active-low reset (clears count)
//   load_i in   load di_i (priority over dec_i)
//   dec_i  in   decrement by one
//   di_i   in   W  load value
//   q_o    out  W  current count
// -----------------------------------------------------------------------------
module transfer_sequencer_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         res,
  input  logic         load_i,
  input  logic         dec_i,
  input  logic [W-1:0] di_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] q_q;

  always_ff @(posedge clk or negedge res) begin
    if (!res)        q_q <= '0;
    else if (load_i) q_q <= di_i;
    else if (dec_i)  q_q <= q_q - W'(1);
  end

  assign q_o = q_q;

endmodule

// File: rtl/transfer_sequencer.sv
// -----------------------------------------------------------------------------
// transfer_sequencer
//   Block-transfer sequencer: IDLE -> LOAD -> (WAIT -> XFER)* -> DONE.
//   Drives the controls of an external address counter and tracks the
//   remaining word count in a sub-module counter.
// Configuration macro:
//   TRANSFER_AUTO_RELOAD_EN : DONE loops back to LOAD with the latched
//                             address/count/dir until abort or reset.
// Ports:
//   clk, res                   clock, async active-low reset
//   start, abort, dir, req     control inputs
//   addr_start, count_start    DATA_LENGTH transfer setup (sampled at start)
//   ack, busy, done            status outputs
//   addr_pl/en/inc/dec/cin     address counter controls (cin active low)
//   addr_di                    DATA_LENGTH address counter load value
//   remaining                  DATA_LENGTH words still to transfer
// -----------------------------------------------------------------------------
module transfer_sequencer
  import transfer_sequencer_pkg::*;
#(
  parameter int DATA_LENGTH = DEFAULT_DATA_LENGTH
) (
  input  logic                   clk,
  input  logic                   res,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   dir,
  input  logic [DATA_LENGTH-1:0] addr_start,
  input  logic [DATA_LENGTH-1:0] count_start,
  input  logic                   req,
  output logic                   ack,
  output logic                   busy,
  output logic                   done,
  output logic                   addr_pl,
  output logic                   addr_en,
  output logic                   addr_inc,
  output logic                   addr_dec,
  output logic                   addr_cin,
  output logic [DATA_LENGTH-1:0] addr_di,
  output logic [DATA_LENGTH-1:0] remaining
);

`ifdef TRANSFER_AUTO_RELOAD_EN
  localparam bit RELOAD = 1'b1;
`else
  localparam bit RELOAD = 1'b0;
`endif

  state_e                 state_q;
  logic                   dir_q;
  logic [DATA_LENGTH-1:0] addr_q;
  logic [DATA_LENGTH-1:0] cnt_q;
  logic [DATA_LENGTH-1:0] rem;
  logic                   cnt_load, cnt_dec;
  logic [DATA_LENGTH-1:0] cnt_di;

  // The count is loaded on entry to LOAD so that remaining already shows the
  // latched count while in LOAD. Abort freezes the count.
  assign cnt_load = (state_q == ST_IDLE && start) ||
                    (RELOAD && state_q == ST_DONE && !abort);
  assign cnt_di   = (state_q == ST_IDLE) ? count_start : cnt_q;
  assign cnt_dec  = (state_q == ST_XFER) && !abort;

  transfer_sequencer_counter #(.W(DATA_LENGTH)) u_cnt (
    .clk    (clk),
    .res    (res),
    .load_i (cnt_load),
    .dec_i  (cnt_dec),
    .di_i   (cnt_di),
    .q_o    (rem)
  );

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q <= ST_IDLE;
      dir_q   <= 1'b0;
      addr_q  <= '0;
      cnt_q   <= '0;
    end else if (state_q != ST_IDLE && abort) begin
      state_q <= ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (start) begin
          state_q <= ST_LOAD;
          dir_q   <= dir;
          addr_q  <= addr_start;
          cnt_q   <= count_start;
        end
        ST_LOAD: state_q <= ST_WAIT;
        ST_WAIT: if (req) state_q <= ST_XFER;
        // Completion is judged on the pre-decrement value, so a loaded 0
        // runs the full 2^DATA_LENGTH words.
        ST_XFER: state_q <= (rem == DATA_LENGTH'(1)) ? ST_DONE : ST_WAIT;
        ST_DONE: state_q <= RELOAD ? ST_LOAD : ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Moore decode from the state register only.
  assign busy      = (state_q != ST_IDLE);
  assign addr_pl   = (state_q == ST_LOAD);
  assign ack       = (state_q == ST_XFER);
  assign addr_en   = (state_q == ST_XFER);
  assign addr_inc  = (state_q == ST_XFER) && !dir_q;
  assign addr_dec  = (state_q == ST_XFER) &&  dir_q;
  assign addr_cin  = (state_q != ST_XFER);
  assign done      = (state_q == ST_DONE);
  assign addr_di   = addr_q;
  assign remaining = rem;

endmodule
